// File: rtl/skid_pipe_stage_pkg.sv
// rtl/skid_pipe_stage_pkg.sv - shared state encodings and default widths for the skid pipeline stage
//
// Purpose: state type for the two-entry elastic stage, default parameter
// values, and a helper that maps a state onto the occupancy it represents.
// Ports: none (package).

package skid_pipe_stage_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_STALL_CNT_W = 16;

    // Number of beats held for a given state; the unused encoding reads as
    // empty so the debug view never reports a phantom beat.
    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            SKID_ONE:  occ = 2'd1;
            SKID_FULL: occ = 2'd2;
            default:   occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/skid_pipe_stage_en_dff.sv
// rtl/skid_pipe_stage_en_dff.sv - single enabled flop cell with async active-high reset
//
// Purpose: one storage bit that loads d when en is high and holds otherwise.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears q
//   en  - load enable
//   d   - next value
//   q   - stored value

module en_dff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_pipe_stage_reg_en_vec.sv
// rtl/skid_pipe_stage_reg_en_vec.sv - WIDTH-bit enabled register bank built from en_dff cells
//
// Purpose: one data slot of the skid stage; all bits share one enable.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears q to 0
//   en  - load enable for the whole bank
//   d   - WIDTH-bit next value
//   q   - WIDTH-bit stored value

module reg_en_vec
    import skid_pipe_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        en_dff u_bit (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (d[i]),
            .q   (q[i])
        );
    end

endmodule

// File: rtl/skid_pipe_stage.sv
// rtl/skid_pipe_stage.sv - two-entry elastic pipeline register with registered ready
//
// Purpose: main + skid slot between two valid/ready interfaces. in_ready is a
// pure decode of the state register, so backpressure never propagates
// combinationally from out_ready to in_ready. Also exports occupancy and a
// saturating count of downstream stall cycles for debug.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   flush     - synchronous discard of all held beats
//   in_valid  - upstream beat valid
//   in_data   - upstream payload
//   in_ready  - stage can accept (from state only)
//   out_valid - downstream beat valid
//   out_data  - downstream payload, always the main slot
//   out_ready - downstream accepts
//   occupancy - beats held (0..2)
//   stall_cnt - saturating count of cycles with out_valid & !out_ready
//   stall_clr - synchronous clear of stall_cnt (wins over increment)

module skid_pipe_stage
    import skid_pipe_stage_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int STALL_CNT_W = DEFAULT_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    skid_state_e state_q;
    skid_state_e state_d;

    logic             accept;
    logic             send;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Outputs are decodes of the state register only.
    assign out_valid = (state_q != SKID_EMPTY);
    assign in_ready  = (state_q != SKID_FULL);
    assign occupancy = state_occupancy(state_q);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_en = 1'b1;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && send) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    skid_en = 1'b1;
                    state_d = SKID_FULL;
                end else if (send) begin
                    // Main keeps its stale value; out_valid masks it.
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                main_d = skid_q;
                if (send) begin
                    main_en = 1'b1;
                    state_d = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
        // Flush drops every held beat but leaves the data flops untouched.
        if (flush) begin
            state_d = SKID_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    reg_en_vec #(
        .WIDTH (WIDTH)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    reg_en_vec #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_skid_pipe_stage.sv
// tb/tb_skid_pipe_stage.sv - self-checking bench for skid_pipe_stage

module tb_skid_pipe_stage;

    localparam int W  = 32;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;
    logic          stall_clr;

    int tests;
    int fails;

    skid_pipe_stage #(
        .WIDTH       (W),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          clr;
        logic          ov;
        logic          ir;
        logic [1:0]    occ;
        logic [W-1:0]  od;
        logic [SW-1:0] st;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic clr);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall_clr = clr;
    endtask

    // Reference model: a FIFO of held beats plus an integer stall counter.
    logic [W-1:0] q[$];
    int           st_m;

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(0, 0, '0, 0, 0);

        // Stream, drain, backpressure fill, FULL refusal, clear, flush.
        //          fl iv d         ordy clr  ov ir occ od      st
        vecs[0]  = '{0, 1, 32'h1,   1, 0,    1, 1, 2'd1, 32'h1, 4'd0};
        vecs[1]  = '{0, 1, 32'h2,   1, 0,    1, 1, 2'd1, 32'h2, 4'd0};
        vecs[2]  = '{0, 1, 32'h3,   1, 0,    1, 1, 2'd1, 32'h3, 4'd0};
        vecs[3]  = '{0, 1, 32'h4,   1, 0,    1, 1, 2'd1, 32'h4, 4'd0};
        vecs[4]  = '{0, 0, 32'h0,   1, 0,    0, 1, 2'd0, 32'h4, 4'd0};
        vecs[5]  = '{0, 1, 32'hA,   0, 0,    1, 1, 2'd1, 32'hA, 4'd0};
        vecs[6]  = '{0, 1, 32'hB,   0, 0,    1, 0, 2'd2, 32'hA, 4'd1};
        vecs[7]  = '{0, 1, 32'hC,   0, 0,    1, 0, 2'd2, 32'hA, 4'd2};
        vecs[8]  = '{0, 1, 32'hC,   1, 0,    1, 1, 2'd1, 32'hB, 4'd2};
        vecs[9]  = '{0, 1, 32'hC,   1, 0,    1, 1, 2'd1, 32'hC, 4'd2};
        vecs[10] = '{0, 0, 32'h0,   1, 0,    0, 1, 2'd0, 32'hC, 4'd2};
        vecs[11] = '{0, 0, 32'h0,   1, 1,    0, 1, 2'd0, 32'hC, 4'd0};
        vecs[12] = '{0, 1, 32'hD,   0, 0,    1, 1, 2'd1, 32'hD, 4'd0};
        vecs[13] = '{0, 1, 32'hE,   0, 0,    1, 0, 2'd2, 32'hD, 4'd1};
        vecs[14] = '{1, 1, 32'hF,   0, 0,    0, 1, 2'd0, 32'hD, 4'd2};
        vecs[15] = '{0, 1, 32'h5,   1, 0,    1, 1, 2'd1, 32'h5, 4'd2};
        vecs[16] = '{0, 0, 32'h0,   1, 0,    0, 1, 2'd0, 32'h5, 4'd2};

        // Reset state while rst is held.
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_occ",       {30'd0, occupancy}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_stall",     {28'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].ir});
            chk($sformatf("vec%0d_occ", i),       {30'd0, occupancy}, {30'd0, vecs[i].occ});
            chk($sformatf("vec%0d_out_data", i),  out_data,           vecs[i].od);
            chk($sformatf("vec%0d_stall", i),     {28'd0, stall_cnt}, {28'd0, vecs[i].st});
        end

        // Stall counter saturation and clear priority.
        @(negedge clk); drive(0, 0, '0, 0, 1);
        @(negedge clk); drive(0, 1, 32'h77, 0, 0);
        @(negedge clk); drive(0, 0, '0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 14) chk("stall_14", {28'd0, stall_cnt}, 32'd14);
            if (c == 15) chk("stall_15", {28'd0, stall_cnt}, 32'd15);
            if (c == 20) chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
            if (c == 20) chk("stall_hold_data", out_data, 32'h77);
            @(negedge clk);
        end
        drive(0, 0, '0, 0, 1);
        @(posedge clk); #1;
        chk("stall_clr_prio", {28'd0, stall_cnt}, 32'd0);

        // Fill to FULL, then assert reset asynchronously mid-cycle.
        @(negedge clk); drive(0, 1, 32'h99, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_full", {30'd0, occupancy}, 32'd2);
        @(negedge clk); drive(0, 0, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("arst_occ",       {30'd0, occupancy}, 32'd0);
        chk("arst_out_data",  out_data,           32'd0);
        chk("arst_stall",     {28'd0, stall_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_idle_data",  out_data,           32'd0);

        // Random traffic against the FIFO model.
        q.delete();
        st_m = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic          r_fl, r_iv, r_ordy, r_clr, ir_a, acc, snd, stalled;
            logic [W-1:0]  r_d, od_before;
            @(negedge clk);
            r_fl   = ($urandom_range(0, 49) == 0);
            r_iv   = ($urandom_range(0, 2) != 0);
            r_ordy = ($urandom_range(0, 2) != 0);
            r_clr  = ($urandom_range(0, 99) == 0);
            r_d    = $urandom;
            drive(r_fl, r_iv, r_d, ~r_ordy, r_clr);
            #1 ir_a = in_ready;
            out_ready = r_ordy;
            #1;
            if ((cyc % 16) == 0)
                chk("in_ready_indep", {31'd0, in_ready}, {31'd0, ir_a});
            od_before = out_data;
            acc     = r_iv && (q.size() < 2);
            snd     = r_ordy && (q.size() > 0);
            stalled = (q.size() > 0) && !r_ordy && !r_fl;
            if (r_clr) st_m = 0;
            else if ((q.size() > 0) && !r_ordy && (st_m < 15)) st_m++;
            if (r_fl) begin
                q.delete();
            end else begin
                if (snd) void'(q.pop_front());
                if (acc) q.push_back(r_d);
            end
            @(posedge clk); #1;
            chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
            chk("rnd_in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < 2)});
            chk("rnd_occ",       {30'd0, occupancy}, q.size());
            chk("rnd_stall",     {28'd0, stall_cnt}, st_m);
            if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
            if (stalled) chk("rnd_hold_data", out_data, od_before);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/skid_pipe_stage.md
Name: skid_pipe_stage

Overview:
- Two-entry elastic pipeline register (main + skid slot) with valid/ready handshake on both sides.
- Inserted between pipeline stages (decode->issue, issue->ALU/LSU) so a registered ready breaks combinational backpressure paths.
- Each data slot is a bank of enabled flops.
- Also exports occupancy and a saturating downstream-stall counter for FPGA debug.

Parameters:
- WIDTH, 32, payload bits per beat.
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held beats.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  stage can accept; registered, never depends combinationally on out_ready.
- out_valid  output  1  downstream beat valid.
- out_data  output  WIDTH  downstream payload, always from main slot.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  beats held: 0, 1 or 2.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- State encoding (2 bits): EMPTY, ONE (main valid), FULL (main + skid valid).
- Outputs from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - occupancy = 0/1/2 for EMPTY/ONE/FULL.
- Accept = in_valid & in_ready; send = out_valid & out_ready.
- Reset (async assert, any cycle): state=EMPTY, main/skid data=0, stall_cnt=0.
  - While rst=1 and after deassertion until first accept: out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Transitions (evaluated at clk edge when flush=0):
  - EMPTY: accept -> main<=in_data, ONE. No accept -> EMPTY.
  - ONE, accept & send -> main<=in_data, stay ONE.
  - ONE, send & !accept -> EMPTY; main data retained, not cleared.
  - ONE, accept & !send -> skid<=in_data, FULL.
  - ONE, neither -> hold.
  - FULL, send -> main<=skid, ONE. No accept possible since in_ready=0; in_valid is ignored.
  - FULL, !send -> hold; both slots stable.
- Latency: accepted beat visible on out_data the cycle after accept when stage was EMPTY or main sent the same cycle. Otherwise it is queued behind the older beat.
- Ordering strictly FIFO; no beat dropped or duplicated absent flush.
- flush=1: next state EMPTY regardless of handshakes.
  - Beats accepted or sent in the flush cycle are discarded and do not count as transferred.
  - Data registers unchanged.
  - stall_cnt not affected by flush.
- Slot enables (enabled-flop semantics; register holds when enable low):
  - main_en = (EMPTY & accept) | (ONE & accept & send) | (FULL & send).
  - main_d = FULL ? skid : in_data.
  - skid_en = ONE & accept & !send.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready.
  - Saturates at all-ones.
  - stall_clr has priority over increment; result 0.
- Holding rule: while out_valid=1 and out_ready=0, out_data must not change.

Decomposition:
- Shared package/definitions header: state encodings SKID_EMPTY=2'd0, SKID_ONE=2'd1, SKID_FULL=2'd2; default width constants.
- One natural sub-module: reg_en_vec, a WIDTH-bit enabled register bank with async active-high reset to 0, per-bit composed of the team's enabled flop cell. It is instantiated twice (main, skid).
- Control FSM and stall counter live in the top module.

Test Plan:
- Reset then idle: rst pulse mid-run with state FULL -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=0; stall_cnt=0.
- Streaming: out_ready=1, in_data=1,2,3,4 back-to-back -> out_data 1,2,3,4 on consecutive cycles, each one cycle after input, occupancy stays 1.
- Backpressure fill: out_ready=0, send 0xA then 0xB -> occupancy 2, in_ready=0. Raise out_ready -> 0xA then 0xB, in order. 0xC offered while FULL is not accepted and appears only after in_ready returns.
- Flush while FULL and in_valid=1 -> next cycle occupancy=0, out_valid=0; subsequent beat 0x5 emerges alone.
- Stall counter: STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). stall_clr pulse -> 0.
- Random valid/ready traffic (10k cycles) against a scoreboard -> no loss, duplication or reorder; out_data stable during stall; in_ready never depends on same-cycle out_ready.
